// File: rtl/isa_pkg.sv
// Shared ISA definitions: instruction field layout, opcode decode helpers and
// the issue bundle handed from decode to execute.
package isa_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned NREG    = 32;
  localparam int unsigned RA_W    = 5;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned STALL_W = 16;

  localparam int unsigned OP_LSB  = 26;
  localparam int unsigned DR_LSB  = 21;
  localparam int unsigned SR1_LSB = 16;
  localparam int unsigned SR2_LSB = 11;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [OP_W-1:0] OP_NOP  = 6'd0;
  localparam logic [OP_W-1:0] OP_ALU  = 6'd1;
  localparam logic [OP_W-1:0] OP_ALUI = 6'd2;
  localparam logic [OP_W-1:0] OP_ST   = 6'd3;
  localparam logic [OP_W-1:0] OP_LD   = 6'd4;
  localparam logic [OP_W-1:0] OP_BR   = 6'd5;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [RA_W-1:0] dr;
    logic            we;
    logic [RA_W-1:0] sr1;
    logic [RA_W-1:0] sr2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } issue_t;

  function automatic logic [OP_W-1:0] op_of(input logic [XLEN-1:0] instr);
    return instr[OP_LSB +: OP_W];
  endfunction

  function automatic logic [RA_W-1:0] dr_of(input logic [XLEN-1:0] instr);
    return instr[DR_LSB +: RA_W];
  endfunction

  function automatic logic [RA_W-1:0] sr1_of(input logic [XLEN-1:0] instr);
    return instr[SR1_LSB +: RA_W];
  endfunction

  function automatic logic [RA_W-1:0] sr2_of(input logic [XLEN-1:0] instr);
    return instr[SR2_LSB +: RA_W];
  endfunction

  function automatic logic [XLEN-1:0] imm_of(input logic [XLEN-1:0] instr);
    return {{(XLEN-IMM_W){instr[IMM_LSB+IMM_W-1]}}, instr[IMM_LSB +: IMM_W]};
  endfunction

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    return (op == OP_NOP) || (op == OP_ALU) || (op == OP_ALUI) ||
           (op == OP_ST)  || (op == OP_LD)  || (op == OP_BR);
  endfunction

  function automatic logic uses_sr1(input logic [OP_W-1:0] op);
    return (op == OP_ALU) || (op == OP_ALUI) || (op == OP_LD) ||
           (op == OP_ST)  || (op == OP_BR);
  endfunction

  function automatic logic uses_sr2(input logic [OP_W-1:0] op);
    return (op == OP_ALU) || (op == OP_ST) || (op == OP_BR);
  endfunction

  function automatic logic writes_dr(input logic [OP_W-1:0] op);
    return (op == OP_ALU) || (op == OP_ALUI) || (op == OP_LD);
  endfunction

endpackage

// File: rtl/decode_issue_if.sv
// Fetch, register-file address, issue, writeback and status signals of the
// decode/issue stage; slave is the stage itself, master its environment.
interface decode_issue_if;
  import isa_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    in_instr;
  logic [XLEN-1:0]    in_pc;
  logic [RA_W-1:0]    sr1;
  logic [RA_W-1:0]    sr2;
  logic               out_valid;
  logic               out_ready;
  logic [OP_W-1:0]    out_op;
  logic [RA_W-1:0]    out_dr;
  logic               out_we;
  logic [XLEN-1:0]    out_imm;
  logic [XLEN-1:0]    out_pc;
  logic               wb_valid;
  logic [RA_W-1:0]    wb_dr;
  logic               flush;
  logic               illegal;
  logic [STALL_W-1:0] stall_cnt;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready, wb_valid, wb_dr, flush,
    output in_ready, sr1, sr2, out_valid, out_op, out_dr, out_we, out_imm,
           out_pc, illegal, stall_cnt
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready, wb_valid, wb_dr, flush,
    input  in_ready, sr1, sr2, out_valid, out_op, out_dr, out_we, out_imm,
           out_pc, illegal, stall_cnt
  );

endinterface

// File: rtl/decode_issue_scoreboard.sv
// Pending-write mask: set on handoff to execute, cleared on writeback (set
// wins on a same-register collision), with two combinational source queries.
module decode_issue_scoreboard
  import isa_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            set_i,
  input  logic [RA_W-1:0] set_idx_i,
  input  logic            clr_i,
  input  logic [RA_W-1:0] clr_idx_i,
  input  logic [RA_W-1:0] q1_idx_i,
  input  logic [RA_W-1:0] q2_idx_i,
  output logic            q1_pend_c_o,
  output logic            q2_pend_c_o,
  output logic [NREG-1:0] pend_o
);

  logic [NREG-1:0] pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    if (clr_i) pend_d[clr_idx_i] = 1'b0;
    if (set_i) pend_d[set_idx_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) pend_q <= '0;
    else         pend_q <= pend_d;
  end

  // No bypass: a writeback this cycle still reads as pending
  assign q1_pend_c_o = pend_q[q1_idx_i];
  assign q2_pend_c_o = pend_q[q2_idx_i];
  assign pend_o      = pend_q;

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: one-entry decode holding register feeding a one-entry
// issue slot aligned with the register file's one-cycle read.
module decode_issue
  import isa_pkg::*;
(
  input logic           clk_i,
  input logic           rst_ni,
  decode_issue_if.slave io
);

  logic               d0_valid_q, d0_valid_d;
  logic [XLEN-1:0]    d0_instr_q, d0_instr_d;
  logic [XLEN-1:0]    d0_pc_q, d0_pc_d;
  logic               os_valid_q, os_valid_d;
  issue_t             os_q, os_d;
  logic               illegal_q, illegal_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic [OP_W-1:0]    d0_op;
  logic [RA_W-1:0]    d0_sr1, d0_sr2;
  logic               d0_use1, d0_use2, d0_legal;
  issue_t             bundle;

  logic               p1, p2, os_hit1, os_hit2;
  logic               hazard, issue, accept, hold, handoff, in_ready_c;
  logic [NREG-1:0]    pend_unused;

  // Decode of the instruction waiting in D0
  always_comb begin
    d0_op       = op_of(d0_instr_q);
    d0_sr1      = sr1_of(d0_instr_q);
    d0_sr2      = sr2_of(d0_instr_q);
    d0_legal    = is_legal(d0_op);
    d0_use1     = uses_sr1(d0_op);
    d0_use2     = uses_sr2(d0_op);
    bundle      = '0;
    bundle.op   = d0_legal ? d0_op : OP_NOP;
    bundle.dr   = dr_of(d0_instr_q);
    bundle.we   = writes_dr(d0_op);
    bundle.sr1  = d0_use1 ? d0_sr1 : '0;
    bundle.sr2  = d0_use2 ? d0_sr2 : '0;
    bundle.imm  = imm_of(d0_instr_q);
    bundle.pc   = d0_pc_q;
  end

  decode_issue_scoreboard u_sb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .set_i       (handoff),
    .set_idx_i   (os_q.dr),
    .clr_i       (io.wb_valid),
    .clr_idx_i   (io.wb_dr),
    .q1_idx_i    (d0_sr1),
    .q2_idx_i    (d0_sr2),
    .q1_pend_c_o (p1),
    .q2_pend_c_o (p2),
    .pend_o      (pend_unused)
  );

  // The slot's destination is not in PEND until its handoff edge
  assign os_hit1    = os_valid_q & os_q.we & (os_q.dr == d0_sr1);
  assign os_hit2    = os_valid_q & os_q.we & (os_q.dr == d0_sr2);
  assign hazard     = d0_valid_q & ((d0_use1 & (p1 | os_hit1)) |
                                    (d0_use2 & (p2 | os_hit2)));
  assign issue      = d0_valid_q & ~hazard & (~os_valid_q | io.out_ready) & ~io.flush;
  assign in_ready_c = ~io.flush & (~d0_valid_q | issue);
  assign accept     = io.in_valid & in_ready_c;
  assign hold       = os_valid_q & ~io.out_ready;
  assign handoff    = os_valid_q & io.out_ready & os_q.we;

  always_comb begin
    d0_valid_d = d0_valid_q;
    d0_instr_d = d0_instr_q;
    d0_pc_d    = d0_pc_q;
    os_valid_d = os_valid_q;
    os_d       = os_q;
    illegal_d  = issue & ~d0_legal;
    stall_d    = stall_q;
    if (hazard && stall_q != '1) stall_d = stall_q + STALL_W'(1);
    if (io.flush) begin
      d0_valid_d = 1'b0;
      os_valid_d = 1'b0;
    end else begin
      if (accept) begin
        d0_valid_d = 1'b1;
        d0_instr_d = io.in_instr;
        d0_pc_d    = io.in_pc;
      end else if (issue) begin
        d0_valid_d = 1'b0;
      end
      if (issue) begin
        os_valid_d = 1'b1;
        os_d       = bundle;
      end else if (io.out_ready) begin
        os_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      d0_valid_q <= 1'b0;
      d0_instr_q <= '0;
      d0_pc_q    <= '0;
      os_valid_q <= 1'b0;
      os_q       <= '0;
      illegal_q  <= 1'b0;
      stall_q    <= '0;
    end else begin
      d0_valid_q <= d0_valid_d;
      d0_instr_q <= d0_instr_d;
      d0_pc_q    <= d0_pc_d;
      os_valid_q <= os_valid_d;
      os_q       <= os_d;
      illegal_q  <= illegal_d;
      stall_q    <= stall_d;
    end
  end

  // A stalled slot re-reads its own operands so the read data stays put
  always_comb begin
    io.sr1 = '0;
    io.sr2 = '0;
    if (hold) begin
      io.sr1 = os_q.sr1;
      io.sr2 = os_q.sr2;
    end else if (d0_valid_q) begin
      io.sr1 = bundle.sr1;
      io.sr2 = bundle.sr2;
    end
  end

  assign io.in_ready  = in_ready_c;
  assign io.out_valid = os_valid_q;
  assign io.out_op    = os_q.op;
  assign io.out_dr    = os_q.dr;
  assign io.out_we    = os_q.we;
  assign io.out_imm   = os_q.imm;
  assign io.out_pc    = os_q.pc;
  assign io.illegal   = illegal_q;
  assign io.stall_cnt = stall_q;

endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: per-cycle vector table plus hand-written
// sequences for back-pressure, reset during a stall and post-reset issue.
module tb_decode_issue;
  import isa_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  decode_issue_if io ();

  decode_issue dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .io     (io.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] instr;
    logic        ordy;
    logic        wbv;
    logic [4:0]  wbdr;
    logic        fl;
    logic        e_irdy;
    logic [4:0]  e_sr1;
    logic [4:0]  e_sr2;
    logic        e_ov;
    logic [5:0]  e_op;
    logic [4:0]  e_dr;
    logic        e_we;
    logic        e_ill;
    logic [31:0] e_pend;
    logic [15:0] e_stall;
  } vec_t;

  localparam int NV = 32;
  vec_t tv [NV];

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] dr,
                                     input logic [4:0] s1, input logic [4:0] s2);
    return {op, dr, s1, s2, 11'd0};
  endfunction

  function automatic vec_t v(input logic iv, input logic [31:0] instr, input logic ordy,
                             input logic wbv, input logic [4:0] wbdr, input logic fl,
                             input logic irdy, input logic [4:0] s1, input logic [4:0] s2,
                             input logic ov, input logic [5:0] op, input logic [4:0] dr,
                             input logic we, input logic ill, input logic [31:0] pend,
                             input logic [15:0] stall);
    vec_t r;
    r.iv = iv; r.instr = instr; r.ordy = ordy; r.wbv = wbv; r.wbdr = wbdr; r.fl = fl;
    r.e_irdy = irdy; r.e_sr1 = s1; r.e_sr2 = s2; r.e_ov = ov; r.e_op = op;
    r.e_dr = dr; r.e_we = we; r.e_ill = ill; r.e_pend = pend; r.e_stall = stall;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic iv, input logic [31:0] instr, input logic [31:0] pc,
                     input logic ordy, input logic wbv, input logic [4:0] wbdr,
                     input logic fl);
    io.in_valid  = iv;
    io.in_instr  = instr;
    io.in_pc     = pc;
    io.out_ready = ordy;
    io.wb_valid  = wbv;
    io.wb_dr     = wbdr;
    io.flush     = fl;
  endtask

  function automatic logic [31:0] pend();
    return dut.u_sb.pend_q;
  endfunction

  logic [31:0] ia, ib, ic, id, ie, ifl, ig, ih, ij, ik, il, im, in_;

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0);

    ia  = mk(6'd1, 5'd1, 5'd2, 5'd3);
    ib  = mk(6'd1, 5'd4, 5'd5, 5'd6);
    ic  = mk(6'd1, 5'd1, 5'd2, 5'd3);
    id  = mk(6'd1, 5'd7, 5'd1, 5'd1);
    ie  = {6'd2, 5'd9, 5'd0, 16'hFFF0};
    ifl = mk(6'h3F, 5'd3, 5'd4, 5'd5);
    ig  = mk(6'd1, 5'd10, 5'd11, 5'd12);
    ih  = mk(6'd1, 5'd13, 5'd14, 5'd15);
    ij  = mk(6'd1, 5'd16, 5'd17, 5'd18);
    ik  = {6'd2, 5'd20, 5'd21, 16'h8001};
    il  = mk(6'd1, 5'd22, 5'd23, 5'd24);
    im  = mk(6'd1, 5'd25, 5'd26, 5'd27);
    in_ = mk(6'd1, 5'd2, 5'd20, 5'd0);

    //          iv instr ordy wbv wbdr fl | irdy sr1 sr2 ov op dr we ill pend stall
    tv[0]  = v(1, ia,  1, 0, 0,  0, 1, 0,  0,  0, 0, 0,  0, 0, 32'h0,     0);
    tv[1]  = v(1, ib,  1, 0, 0,  0, 1, 2,  3,  0, 0, 0,  0, 0, 32'h0,     0);
    tv[2]  = v(0, 0,   1, 0, 0,  0, 1, 5,  6,  1, 1, 1,  1, 0, 32'h0,     0);
    tv[3]  = v(0, 0,   1, 0, 0,  0, 1, 0,  0,  1, 1, 4,  1, 0, 32'h2,     0);
    tv[4]  = v(0, 0,   1, 1, 1,  0, 1, 0,  0,  0, 0, 0,  0, 0, 32'h12,    0);
    tv[5]  = v(0, 0,   1, 1, 4,  0, 1, 0,  0,  0, 0, 0,  0, 0, 32'h10,    0);
    tv[6]  = v(1, ic,  1, 0, 0,  0, 1, 0,  0,  0, 0, 0,  0, 0, 32'h0,     0);
    tv[7]  = v(1, id,  1, 0, 0,  0, 1, 2,  3,  0, 0, 0,  0, 0, 32'h0,     0);
    tv[8]  = v(0, 0,   1, 0, 0,  0, 0, 1,  1,  1, 1, 1,  1, 0, 32'h0,     0);
    tv[9]  = v(0, 0,   1, 0, 0,  0, 0, 1,  1,  0, 0, 0,  0, 0, 32'h2,     1);
    tv[10] = v(0, 0,   1, 0, 0,  0, 0, 1,  1,  0, 0, 0,  0, 0, 32'h2,     2);
    tv[11] = v(0, 0,   1, 0, 0,  0, 0, 1,  1,  0, 0, 0,  0, 0, 32'h2,     3);
    tv[12] = v(0, 0,   1, 1, 1,  0, 0, 1,  1,  0, 0, 0,  0, 0, 32'h2,     4);
    tv[13] = v(0, 0,   1, 0, 0,  0, 1, 1,  1,  0, 0, 0,  0, 0, 32'h0,     5);
    tv[14] = v(0, 0,   1, 0, 0,  0, 1, 0,  0,  1, 1, 7,  1, 0, 32'h0,     5);
    tv[15] = v(0, 0,   1, 1, 7,  0, 1, 0,  0,  0, 0, 0,  0, 0, 32'h80,    5);
    tv[16] = v(1, ie,  1, 0, 0,  0, 1, 0,  0,  0, 0, 0,  0, 0, 32'h0,     5);
    tv[17] = v(0, 0,   1, 0, 0,  0, 1, 0,  0,  0, 0, 0,  0, 0, 32'h0,     5);
    tv[18] = v(0, 0,   1, 1, 9,  0, 1, 0,  0,  1, 2, 9,  1, 0, 32'h0,     5);
    tv[19] = v(0, 0,   1, 0, 0,  0, 1, 0,  0,  0, 0, 0,  0, 0, 32'h200,   5);
    tv[20] = v(1, ifl, 1, 0, 0,  0, 1, 0,  0,  0, 0, 0,  0, 0, 32'h200,   5);
    tv[21] = v(0, 0,   1, 0, 0,  0, 1, 0,  0,  0, 0, 0,  0, 0, 32'h200,   5);
    tv[22] = v(1, ig,  1, 0, 0,  0, 1, 0,  0,  1, 0, 3,  0, 1, 32'h200,   5);
    tv[23] = v(1, ih,  1, 0, 0,  0, 1, 11, 12, 0, 0, 0,  0, 0, 32'h200,   5);
    tv[24] = v(0, 0,   0, 0, 0,  0, 0, 11, 12, 1, 1, 10, 1, 0, 32'h200,   5);
    tv[25] = v(1, ij,  0, 0, 0,  1, 0, 11, 12, 1, 1, 10, 1, 0, 32'h200,   5);
    tv[26] = v(1, ij,  1, 0, 0,  0, 1, 0,  0,  0, 0, 0,  0, 0, 32'h200,   5);
    tv[27] = v(0, 0,   1, 0, 0,  0, 1, 17, 18, 0, 0, 0,  0, 0, 32'h200,   5);
    tv[28] = v(0, 0,   1, 0, 0,  0, 1, 0,  0,  1, 1, 16, 1, 0, 32'h200,   5);
    tv[29] = v(0, 0,   1, 1, 9,  0, 1, 0,  0,  0, 0, 0,  0, 0, 32'h10200, 5);
    tv[30] = v(0, 0,   1, 1, 16, 0, 1, 0,  0,  0, 0, 0,  0, 0, 32'h10000, 5);
    tv[31] = v(0, 0,   1, 0, 0,  0, 1, 0,  0,  0, 0, 0,  0, 0, 32'h0,     5);

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst.out_valid", 32'(io.out_valid), 32'd0);
    chk("rst.in_ready",  32'(io.in_ready),  32'd1);
    chk("rst.stall_cnt", 32'(io.stall_cnt), 32'd0);
    chk("rst.illegal",   32'(io.illegal),   32'd0);
    chk("rst.pend",      pend(),            32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drv(tv[i].iv, tv[i].instr, 32'h100 + 32'(i) * 4, tv[i].ordy, tv[i].wbv,
          tv[i].wbdr, tv[i].fl);
      #1;
      chk($sformatf("r%0d.in_ready", i),  32'(io.in_ready),  32'(tv[i].e_irdy));
      chk($sformatf("r%0d.sr1", i),       32'(io.sr1),       32'(tv[i].e_sr1));
      chk($sformatf("r%0d.sr2", i),       32'(io.sr2),       32'(tv[i].e_sr2));
      chk($sformatf("r%0d.out_valid", i), 32'(io.out_valid), 32'(tv[i].e_ov));
      chk($sformatf("r%0d.illegal", i),   32'(io.illegal),   32'(tv[i].e_ill));
      chk($sformatf("r%0d.pend", i),      pend(),            tv[i].e_pend);
      chk($sformatf("r%0d.stall", i),     32'(io.stall_cnt), 32'(tv[i].e_stall));
      if (tv[i].e_ov) begin
        chk($sformatf("r%0d.out_op", i), 32'(io.out_op), 32'(tv[i].e_op));
        chk($sformatf("r%0d.out_dr", i), 32'(io.out_dr), 32'(tv[i].e_dr));
        chk($sformatf("r%0d.out_we", i), 32'(io.out_we), 32'(tv[i].e_we));
      end
    end

    // Back-pressure: slot held 5 cycles, then drains K, L, M exactly once
    @(negedge clk); drv(1, ik, 32'h1000, 0, 0, 0, 0);
    @(negedge clk); drv(1, il, 32'h1004, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); drv(1, im, 32'h1008, 0, 0, 0, 0);
      #1;
      chk($sformatf("hold%0d.out_valid", c), 32'(io.out_valid), 32'd1);
      chk($sformatf("hold%0d.out_op", c),    32'(io.out_op),    32'd2);
      chk($sformatf("hold%0d.out_dr", c),    32'(io.out_dr),    32'd20);
      chk($sformatf("hold%0d.out_imm", c),   io.out_imm,        32'hFFFF8001);
      chk($sformatf("hold%0d.out_pc", c),    io.out_pc,         32'h1000);
      chk($sformatf("hold%0d.sr1", c),       32'(io.sr1),       32'd21);
      chk($sformatf("hold%0d.sr2", c),       32'(io.sr2),       32'd0);
      chk($sformatf("hold%0d.in_ready", c),  32'(io.in_ready),  32'd0);
    end
    @(negedge clk); drv(1, im, 32'h1008, 1, 0, 0, 0);
    #1;
    chk("rel.out_dr",   32'(io.out_dr),   32'd20);
    chk("rel.in_ready", 32'(io.in_ready), 32'd1);
    chk("rel.sr1",      32'(io.sr1),      32'd23);
    chk("rel.sr2",      32'(io.sr2),      32'd24);
    @(negedge clk); drv(0, 0, 0, 1, 0, 0, 0);
    #1;
    chk("rel.L.valid", 32'(io.out_valid), 32'd1);
    chk("rel.L.dr",    32'(io.out_dr),    32'd22);
    chk("rel.L.pc",    io.out_pc,         32'h1004);
    chk("rel.M.sr1",   32'(io.sr1),       32'd26);
    @(negedge clk);
    #1;
    chk("rel.M.valid", 32'(io.out_valid), 32'd1);
    chk("rel.M.dr",    32'(io.out_dr),    32'd25);
    chk("rel.M.pc",    io.out_pc,         32'h1008);
    @(negedge clk);
    #1;
    chk("rel.drained", 32'(io.out_valid), 32'd0);
    chk("rel.pend",    pend(),            32'h0250_0000);

    // Reset while an instruction is stalled on pending R20
    @(negedge clk); drv(1, in_, 32'h2000, 1, 0, 0, 0);
    @(negedge clk); drv(0, 0, 0, 1, 0, 0, 0);
    #1;
    chk("stl.in_ready", 32'(io.in_ready), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    chk("stl.stall_cnt", 32'(io.stall_cnt), 32'd8);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("mrst.out_valid", 32'(io.out_valid), 32'd0);
    chk("mrst.stall_cnt", 32'(io.stall_cnt), 32'd0);
    chk("mrst.pend",      pend(),            32'd0);
    chk("mrst.out_op",    32'(io.out_op),    32'd0);
    chk("mrst.out_dr",    32'(io.out_dr),    32'd0);
    chk("mrst.out_we",    32'(io.out_we),    32'd0);
    chk("mrst.out_imm",   io.out_imm,        32'd0);
    chk("mrst.out_pc",    io.out_pc,         32'd0);
    chk("mrst.illegal",   32'(io.illegal),   32'd0);
    rst_n = 1'b1;

    // Normal issue after reset
    @(negedge clk); drv(1, ia, 32'h3000, 1, 0, 0, 0);
    #1;
    chk("post.in_ready", 32'(io.in_ready), 32'd1);
    @(negedge clk); drv(0, 0, 0, 1, 0, 0, 0);
    #1;
    chk("post.sr1", 32'(io.sr1), 32'd2);
    @(negedge clk);
    #1;
    chk("post.out_valid", 32'(io.out_valid), 32'd1);
    chk("post.out_pc",    io.out_pc,         32'h3000);
    chk("post.stall_cnt", 32'(io.stall_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
